// File: rtl/axioma_gpio_pkg.sv
// rtl/axioma_gpio_pkg.sv - shared constants and address-map check for the GPIO/pin-change block
package axioma_gpio_pkg;

    localparam logic [5:0] DEF_PORT_BASE  = 6'h23;
    localparam logic [5:0] DEF_PCMSK_BASE = 6'h2C;
    localparam logic [5:0] DEF_PCICR_ADDR = 6'h2F;
    localparam logic [5:0] DEF_PCIFR_ADDR = 6'h3B;

    localparam int OFF_PIN  = 0;
    localparam int OFF_DDR  = 1;
    localparam int OFF_PORT = 2;

    localparam int MAX_PORTS = 8;
    localparam int MAX_WIDTH = 8;

    // True when every register address fits in the 6-bit space and no two collide.
    function automatic bit addr_map_ok(input int port_base, input int pcmsk_base,
                                       input int pcicr_addr, input int pcifr_addr,
                                       input int num_ports);
        logic [63:0] used;
        bit          ok;
        int          a;
        used = '0;
        ok   = 1'b1;
        for (int i = 0; i < 3 * num_ports; i++) begin
            a = port_base + i;
            if (a > 63 || used[a]) ok = 1'b0;
            else used[a] = 1'b1;
        end
        for (int i = 0; i < num_ports; i++) begin
            a = pcmsk_base + i;
            if (a > 63 || used[a]) ok = 1'b0;
            else used[a] = 1'b1;
        end
        if (pcicr_addr > 63 || used[pcicr_addr]) ok = 1'b0;
        else used[pcicr_addr] = 1'b1;
        if (pcifr_addr > 63 || used[pcifr_addr]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/axioma_gpio_pcint_if.sv
// rtl/axioma_gpio_pcint_if.sv - CPU I/O register bus seen by the GPIO block
interface axioma_gpio_pcint_if;
    logic [5:0] io_addr;
    logic [7:0] io_data_in;
    logic [7:0] io_data_out;
    logic       io_read;
    logic       io_write;

    modport master (output io_addr, output io_data_in, output io_read, output io_write,
                    input  io_data_out);
    modport slave  (input  io_addr, input  io_data_in, input  io_read, input  io_write,
                    output io_data_out);
endinterface

// File: rtl/axioma_gpio_sync.sv
// rtl/axioma_gpio_sync.sv - multi-flop pad synchroniser with one-cycle change detect
module axioma_gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] chg
);

    logic [WIDTH-1:0] stg_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
            prev_q <= '0;
        end else begin
            stg_q[0] <= pin;
            for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
            prev_q <= stg_q[STAGES-1];
        end
    end

    assign sync = stg_q[STAGES-1];
    assign chg  = stg_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/axioma_gpio_pcint.sv
// rtl/axioma_gpio_pcint.sv - parametrised GPIO ports with AVR pin-change interrupts
module axioma_gpio_pcint
    import axioma_gpio_pkg::*;
#(
    parameter int         NUM_PORTS   = 3,
    parameter int         PORT_WIDTH  = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] PORT_BASE   = DEF_PORT_BASE,
    parameter logic [5:0] PCMSK_BASE  = DEF_PCMSK_BASE,
    parameter logic [5:0] PCICR_ADDR  = DEF_PCICR_ADDR,
    parameter logic [5:0] PCIFR_ADDR  = DEF_PCIFR_ADDR
) (
    input  logic                            clk,
    input  logic                            reset_n,
    axioma_gpio_pcint_if.slave              bus,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pin_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] ddr_out,
    output logic [NUM_PORTS-1:0]            pcint_irq,
    input  logic [NUM_PORTS-1:0]            pcint_ack
);

    if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS || PORT_WIDTH < 1 || PORT_WIDTH > MAX_WIDTH ||
        SYNC_STAGES < 2 ||
        !addr_map_ok(int'(PORT_BASE), int'(PCMSK_BASE), int'(PCICR_ADDR), int'(PCIFR_ADDR),
                     NUM_PORTS)) begin : g_bad_cfg
        $error("axioma_gpio_pcint: illegal parameters or overlapping register map");
    end

    logic [PORT_WIDTH-1:0]  wdata;
    logic [NUM_PORTS*8-1:0] rd_vec;
    logic [NUM_PORTS-1:0]   pc_set;
    logic [NUM_PORTS-1:0]   pc_clr;
    logic [NUM_PORTS-1:0]   pcicr_q;
    logic [NUM_PORTS-1:0]   pcifr_q;
    logic                   sel_icr;
    logic                   sel_ifr;
    logic [7:0]             rd_data;

    assign wdata   = bus.io_data_in[PORT_WIDTH-1:0];
    assign sel_icr = (bus.io_addr == PCICR_ADDR);
    assign sel_ifr = (bus.io_addr == PCIFR_ADDR);

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        localparam logic [5:0] A_PIN  = 6'(int'(PORT_BASE) + 3 * k + OFF_PIN);
        localparam logic [5:0] A_DDR  = 6'(int'(PORT_BASE) + 3 * k + OFF_DDR);
        localparam logic [5:0] A_PORT = 6'(int'(PORT_BASE) + 3 * k + OFF_PORT);
        localparam logic [5:0] A_MSK  = 6'(int'(PCMSK_BASE) + k);

        logic [PORT_WIDTH-1:0] port_q, ddr_q, msk_q, sync_k, chg_k;
        logic                  sel_pin, sel_ddr, sel_port, sel_msk;

        assign sel_pin  = (bus.io_addr == A_PIN);
        assign sel_ddr  = (bus.io_addr == A_DDR);
        assign sel_port = (bus.io_addr == A_PORT);
        assign sel_msk  = (bus.io_addr == A_MSK);

        axioma_gpio_sync #(
            .WIDTH  (PORT_WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (pin_in[k*PORT_WIDTH +: PORT_WIDTH]),
            .sync    (sync_k),
            .chg     (chg_k)
        );

        // Writing PIN toggles PORT, matching AVR behaviour; PIN itself is read-only.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                port_q <= '0;
                ddr_q  <= '0;
                msk_q  <= '0;
            end else if (bus.io_write) begin
                if (sel_port)     port_q <= wdata;
                else if (sel_pin) port_q <= port_q ^ wdata;
                if (sel_ddr)      ddr_q  <= wdata;
                if (sel_msk)      msk_q  <= wdata;
            end
        end

        assign port_out[k*PORT_WIDTH +: PORT_WIDTH] = port_q;
        assign ddr_out[k*PORT_WIDTH +: PORT_WIDTH]  = ddr_q;
        // Uses the registered mask, so a same-cycle PCMSK write sees the old value.
        assign pc_set[k] = |(chg_k & msk_q);
        assign rd_vec[k*8 +: 8] = sel_pin  ? 8'(sync_k) :
                                  sel_ddr  ? 8'(ddr_q)  :
                                  sel_port ? 8'(port_q) :
                                  sel_msk  ? 8'(msk_q)  : 8'h00;
    end

    assign pc_clr = ((bus.io_write && sel_ifr) ? bus.io_data_in[NUM_PORTS-1:0] : '0) | pcint_ack;

    // Set has priority over W1C and acknowledge so a change arriving during a clear is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcicr_q <= '0;
            pcifr_q <= '0;
        end else begin
            if (bus.io_write && sel_icr) pcicr_q <= bus.io_data_in[NUM_PORTS-1:0];
            pcifr_q <= (pcifr_q & ~pc_clr) | pc_set;
        end
    end

    assign pcint_irq = pcifr_q & pcicr_q;

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_PORTS; k++) rd_data = rd_data | rd_vec[k*8 +: 8];
        if (sel_icr) rd_data = rd_data | 8'(pcicr_q);
        if (sel_ifr) rd_data = rd_data | 8'(pcifr_q);
    end

    assign bus.io_data_out = bus.io_read ? rd_data : 8'h00;

endmodule

// File: tb/tb_axioma_gpio_pcint.sv
// tb/tb_axioma_gpio_pcint.sv - self-checking bench for axioma_gpio_pcint
`timescale 1ns/100ps
module tb_axioma_gpio_pcint;

    localparam int NP = 3;
    localparam int PW = 8;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axioma_gpio_pcint_if bus ();
    axioma_gpio_pcint_if bus7 ();

    logic [NP*PW-1:0] pin_in, port_out, ddr_out;
    logic [NP-1:0]    irq, ack;
    logic [13:0]      pin7, port7, ddr7;
    logic [1:0]       irq7, ack7;

    int n_checks = 0;
    int n_errors = 0;

    axioma_gpio_pcint dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .pin_in    (pin_in),
        .port_out  (port_out),
        .ddr_out   (ddr_out),
        .pcint_irq (irq),
        .pcint_ack (ack)
    );

    axioma_gpio_pcint #(.NUM_PORTS(2), .PORT_WIDTH(7)) dut7 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus7),
        .pin_in    (pin7),
        .port_out  (port7),
        .ddr_out   (ddr7),
        .pcint_irq (irq7),
        .pcint_ack (ack7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register map plus a history of pad samples; sync is the sample S-1 edges old.
    logic [7:0]       m_port [NP];
    logic [7:0]       m_ddr  [NP];
    logic [7:0]       m_msk  [NP];
    logic [NP-1:0]    m_icr, m_ifr;
    logic [NP*PW-1:0] samp [S+1];

    always @(posedge clk or negedge reset_n) begin : model
        logic [NP*PW-1:0] chg;
        logic [NP-1:0]    set, clr;
        if (!reset_n) begin
            for (int k = 0; k < NP; k++) begin
                m_port[k] = 8'h00; m_ddr[k] = 8'h00; m_msk[k] = 8'h00;
            end
            m_icr = '0;
            m_ifr = '0;
            for (int i = 0; i <= S; i++) samp[i] = '0;
        end else begin
            chg = samp[S-1] ^ samp[S];
            for (int k = 0; k < NP; k++) set[k] = |(chg[k*8 +: 8] & m_msk[k]);
            clr = ack;
            if (bus.io_write && bus.io_addr == 6'h3B) clr = clr | bus.io_data_in[NP-1:0];
            m_ifr = (m_ifr & ~clr) | set;
            if (bus.io_write) begin
                for (int k = 0; k < NP; k++) begin
                    if (bus.io_addr == 6'(8'h23 + 3 * k))     m_port[k] = m_port[k] ^ bus.io_data_in;
                    if (bus.io_addr == 6'(8'h23 + 3 * k + 1)) m_ddr[k]  = bus.io_data_in;
                    if (bus.io_addr == 6'(8'h23 + 3 * k + 2)) m_port[k] = bus.io_data_in;
                    if (bus.io_addr == 6'(8'h2C + k))         m_msk[k]  = bus.io_data_in;
                end
                if (bus.io_addr == 6'h2F) m_icr = bus.io_data_in[NP-1:0];
            end
            for (int i = S; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = pin_in;
        end
    end

    function automatic logic [7:0] model_read(input logic [5:0] a);
        logic [7:0]       r;
        logic [NP*PW-1:0] sy;
        r  = 8'h00;
        sy = samp[S-1];
        for (int k = 0; k < NP; k++) begin
            if (a == 6'(8'h23 + 3 * k))     r = sy[k*8 +: 8];
            if (a == 6'(8'h23 + 3 * k + 1)) r = m_ddr[k];
            if (a == 6'(8'h23 + 3 * k + 2)) r = m_port[k];
            if (a == 6'(8'h2C + k))         r = m_msk[k];
        end
        if (a == 6'h2F) r = 8'(m_icr);
        if (a == 6'h3B) r = 8'(m_ifr);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            logic [NP*PW-1:0] ep, ed;
            for (int k = 0; k < NP; k++) begin
                ep[k*8 +: 8] = m_port[k];
                ed[k*8 +: 8] = m_ddr[k];
            end
            check("port_out", port_out, ep);
            check("ddr_out", ddr_out, ed);
            check("pcint_irq", irq, m_ifr & m_icr);
            check("io_data_out", bus.io_data_out, bus.io_read ? model_read(bus.io_addr) : 8'h00);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.io_addr = a; bus.io_data_in = d; bus.io_write = 1'b1;
        cyc(1);
        bus.io_write = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [5:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus.io_addr = a; bus.io_read = 1'b1;
        @(negedge clk);
        d = bus.io_data_out;
        check(name, d, exp);
        cyc(1);
        bus.io_read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.io_addr = '0; bus.io_data_in = '0; bus.io_read = 1'b0; bus.io_write = 1'b0;
        bus7.io_addr = '0; bus7.io_data_in = '0; bus7.io_read = 1'b0; bus7.io_write = 1'b0;
        ack = '0; pin7 = '0; ack7 = '0;
        pin_in = 24'($urandom);
        reset_n = 1'b0;
        cyc(3);

        check("rst_port_out", port_out, 24'h0);
        check("rst_ddr_out", ddr_out, 24'h0);
        check("rst_irq", irq, 3'b000);
        for (int a = 'h23; a <= 'h2F; a++) rdchk("rst_read", 6'(a), 8'h00);
        rdchk("rst_pcifr", 6'h3B, 8'h00);

        reset_n = 1'b1;
        cyc(6);
        pin_in = '0;
        cyc(6);
        check("no_flag_after_release", irq, 3'b000);
        rdchk("pcifr_after_release", 6'h3B, 8'h00);
        rdchk("unmapped_00", 6'h00, 8'h00);
        rdchk("unmapped_3f", 6'h3F, 8'h00);

        wr(6'h27, 8'h7F);
        wr(6'h28, 8'h55);
        rdchk("ddr1", 6'h27, 8'h7F);
        rdchk("port1", 6'h28, 8'h55);
        check("port_out1", port_out[15:8], 8'h55);

        wr(6'h25, 8'hA5);
        wr(6'h23, 8'h0F);
        rdchk("pin0_toggle", 6'h25, 8'hAA);
        wr(6'h23, 8'h00);
        rdchk("pin0_zero", 6'h25, 8'hAA);

        wr(6'h2E, 8'h01);
        wr(6'h2F, 8'h04);
        pin_in[16] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("irq_early", irq[2], 1'b0);
        @(negedge clk);
        check("irq_at_3", irq[2], 1'b1);
        cyc(1);
        rdchk("pcifr_set", 6'h3B, 8'h04);

        wr(6'h3B, 8'h04);
        check("irq_after_w1c", irq, 3'b000);
        rdchk("pcifr_w1c", 6'h3B, 8'h00);

        pin_in[17] = 1'b1;
        cyc(5);
        rdchk("unmasked_pin", 6'h3B, 8'h00);

        pin_in[16] = 1'b0;
        cyc(2);
        wr(6'h3B, 8'h04);
        rdchk("set_beats_w1c", 6'h3B, 8'h04);

        ack = 3'b100;
        cyc(1);
        ack = '0;
        check("irq_after_ack", irq, 3'b000);
        rdchk("pcifr_ack", 6'h3B, 8'h00);

        pin_in[16] = 1'b1;
        cyc(4);
        check("irq_before_reset", irq, 3'b100);
        pin_in = '0;
        #1;
        reset_n = 1'b0;
        #0.5;
        check("irq_async_reset", irq, 3'b000);
        check("port_async_reset", port_out, 24'h0);
        #0.5;
        reset_n = 1'b1;
        cyc(1);
        for (int a = 'h23; a <= 'h2F; a++) rdchk("post_reset_read", 6'(a), 8'h00);
        rdchk("post_reset_pcifr", 6'h3B, 8'h00);

        bus7.io_addr = 6'h25; bus7.io_data_in = 8'hFF; bus7.io_write = 1'b1;
        cyc(1);
        bus7.io_write = 1'b0; bus7.io_read = 1'b1;
        @(negedge clk);
        check("w7_readback", bus7.io_data_out, 8'h7F);
        check("w7_port_out", port7[6:0], 7'h7F);
        cyc(1);
        bus7.io_read = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
